// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: ROM port, redirect request and the IR handshake.
// master = fetch stage, slave = ROM/execute side.
interface instr_fetch_if #(
  parameter int PC_W = 4
);
  logic [PC_W-1:0] rom_addr;
  logic [15:0]     rom_instr;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            ir_valid;
  logic            ir_ready;
  logic [15:0]     ir_instr;
  logic [PC_W-1:0] ir_pc;
  logic [3:0]      ir_opcode;
  logic [2:0]      ir_rd;
  logic [2:0]      ir_rs;
  logic [7:0]      ir_imm;
  logic [3:0]      ir_target;

  modport master (
    output rom_addr,
    input  rom_instr,
    input  redirect_valid,
    input  redirect_pc,
    output ir_valid,
    input  ir_ready,
    output ir_instr,
    output ir_pc,
    output ir_opcode,
    output ir_rd,
    output ir_rs,
    output ir_imm,
    output ir_target
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    output redirect_valid,
    output redirect_pc,
    input  ir_valid,
    output ir_ready,
    input  ir_instr,
    input  ir_pc,
    input  ir_opcode,
    input  ir_rd,
    input  ir_rs,
    input  ir_imm,
    input  ir_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, combinational ROM address, IR with split fields.
// Optional jmp folding in fetch: define INSTR_FETCH_JMP_FOLD_EN.
module instr_fetch #(
  parameter int PC_W     = 4,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [0:0]      S_EMPTY = 1'b0;
  localparam logic [0:0]      S_FULL  = 1'b1;
`ifdef INSTR_FETCH_JMP_FOLD_EN
  localparam logic [3:0]      OP_JMP  = 4'b1000;
`endif

  logic [PC_W-1:0] pc_q, pc_d;
  logic [0:0]      state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic [PC_W-1:0] irpc_q, irpc_d;
  logic            load_en;

  // next-state: redirect beats jmp fold beats a normal load; else hold
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    instr_d = instr_q;
    irpc_d  = irpc_q;
    load_en = (state_q == S_EMPTY) || bus.ir_ready;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = S_EMPTY;
    end else if (load_en) begin
`ifdef INSTR_FETCH_JMP_FOLD_EN
      if (bus.rom_instr[15:12] == OP_JMP) begin
        pc_d    = PC_W'(bus.rom_instr[11:8]);
        state_d = S_EMPTY;
      end else begin
        instr_d = bus.rom_instr;
        irpc_d  = pc_q;
        pc_d    = pc_q + PC_ONE;
        state_d = S_FULL;
      end
`else
      instr_d = bus.rom_instr;
      irpc_d  = pc_q;
      pc_d    = pc_q + PC_ONE;
      state_d = S_FULL;
`endif
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= PC_RST;
      state_q <= S_EMPTY;
      instr_q <= '0;
      irpc_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      instr_q <= instr_d;
      irpc_q  <= irpc_d;
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.ir_valid  = (state_q == S_FULL);
  assign bus.ir_instr  = instr_q;
  assign bus.ir_pc     = irpc_q;
  assign bus.ir_opcode = instr_q[15:12];
  assign bus.ir_rd     = instr_q[11:9];
  assign bus.ir_rs     = instr_q[8:6];
  assign bus.ir_imm    = instr_q[7:0];
  assign bus.ir_target = instr_q[11:8];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, scoreboard of accepted words.
// Expectations follow INSTR_FETCH_JMP_FOLD_EN when it is defined.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  logic [15:0] rom [16];

  int n_chk;
  int n_fail;

  typedef struct {
    logic [3:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];

  instr_fetch_if #(.PC_W(4)) bus ();

  instr_fetch #(
    .PC_W(4),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  assign bus.rom_instr = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] pc, input logic [15:0] w);
    exp_t e;
    e.pc    = pc;
    e.instr = w;
    sb.push_back(e);
  endtask

  // monitor: every accepted (not flushed) IR word must match the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ir_valid === 1'b1 &&
        bus.ir_ready === 1'b1 && bus.redirect_valid === 1'b0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %0h instr %0h expected none",
                 bus.ir_pc, bus.ir_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", 32'(bus.ir_pc), 32'(e.pc));
        chk("sb_instr", 32'(bus.ir_instr), 32'(e.instr));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 4; i < 16; i++) rom[i] = 16'(i * 16'h0111);
    rom[0] = 16'hB401;
    rom[1] = 16'h3481;
    rom[2] = 16'hF400;
    rom[3] = 16'h8100;

    rst_n              = 1'b0;
    bus.ir_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 4'd0;

    // reset held for two edges
    tick();
    tick();
    chk("rst_valid", 32'(bus.ir_valid), 0);
    chk("rst_instr", 32'(bus.ir_instr), 0);
    chk("rst_pc", 32'(bus.ir_pc), 0);
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_fields", {bus.ir_opcode, bus.ir_rd, bus.ir_rs,
                       bus.ir_imm, bus.ir_target}, 0);

    push(4'd0, 16'hB401);
    push(4'd1, 16'h3481);
    push(4'd2, 16'hF400);
    rst_n = 1'b1;

    // first edge after release: word 0
    tick();
    chk("w0_valid", 32'(bus.ir_valid), 1);
    chk("w0_pc", 32'(bus.ir_pc), 0);
    chk("w0_rd", 32'(bus.ir_rd), 2);
    chk("w0_imm", 32'(bus.ir_imm), 1);
    chk("w0_op", 32'(bus.ir_opcode), 32'hB);
    chk("w0_target", 32'(bus.ir_target), 4);

    // word 1, then stall three cycles
    tick();
    chk("w1_pc", 32'(bus.ir_pc), 1);
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(bus.ir_valid), 1);
      chk("stall_instr", 32'(bus.ir_instr), 32'h3481);
      chk("stall_addr", 32'(bus.rom_addr), 2);
    end
    bus.ir_ready = 1'b1;

    tick();
    chk("w2_pc", 32'(bus.ir_pc), 2);

`ifdef INSTR_FETCH_JMP_FOLD_EN
    tick();
    chk("fold_bubble", 32'(bus.ir_valid), 0);
    tick();
    chk("fold_tgt_valid", 32'(bus.ir_valid), 1);
    chk("fold_tgt_pc", 32'(bus.ir_pc), 1);
`else
    push(4'd3, 16'h8100);
    tick();
    chk("jmp_pc", 32'(bus.ir_pc), 3);
    chk("jmp_target", 32'(bus.ir_target), 1);
    tick();
    chk("jmp_seq_pc", 32'(bus.ir_pc), 4);
`endif

    // redirect with simultaneous ready: word on IR is flushed
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 4'd10;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_valid", 32'(bus.ir_valid), 0);
    chk("redir_addr", 32'(bus.rom_addr), 10);

    for (int p = 10; p < 16; p++) push(4'(p), rom[p]);
    for (int p = 10; p < 16; p++) begin
      tick();
      chk("seq_pc", 32'(bus.ir_pc), 32'(p));
    end
    // wrap 15 -> 0
    tick();
    chk("wrap_pc", 32'(bus.ir_pc), 0);
    chk("wrap_instr", 32'(bus.ir_instr), 32'hB401);
    bus.ir_ready = 1'b0;

    // mid-stall reset
    tick();
    chk("hold_pc", 32'(bus.ir_pc), 0);
    chk("hold_addr", 32'(bus.rom_addr), 1);
    rst_n = 1'b0;
    tick();
    chk("mrst_valid", 32'(bus.ir_valid), 0);
    chk("mrst_addr", 32'(bus.rom_addr), 0);
    chk("mrst_instr", 32'(bus.ir_instr), 0);
    rst_n        = 1'b1;
    bus.ir_ready = 1'b1;
    push(4'd0, 16'hB401);
    tick();
    chk("reissue_valid", 32'(bus.ir_valid), 1);
    chk("reissue_pc", 32'(bus.ir_pc), 0);
    @(negedge clk);
    #1;
    bus.ir_ready = 1'b0;
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit, 16-word processor. Owns the program counter, drives the combinational program ROM address, captures the returned word into an instruction register, and presents it with pre-split fields to the execute stage over a valid/ready handshake. Execute-stage redirects (taken `br`) flush the register and reload the PC.

## Interface
Parameters:
- `PC_W`, 4: PC / ROM address width; ROM depth is 2^PC_W.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `rom_addr`  out  PC_W  ROM address; equals PC.
- `rom_instr`  in  16  ROM data; valid in the same cycle as `rom_addr`.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_pc`  in  PC_W  new PC when `redirect_valid`.
- `ir_valid`  out  1  instruction register holds an instruction.
- `ir_ready`  in  1  execute accepts it this cycle.
- `ir_instr`  out  16  raw instruction.
- `ir_pc`  out  PC_W  address it was fetched from.
- `ir_opcode`  out  4  `ir_instr[15:12]`.
- `ir_rd`  out  3  `ir_instr[11:9]`.
- `ir_rs`  out  3  `ir_instr[8:6]`.
- `ir_imm`  out  8  `ir_instr[7:0]`.
- `ir_target`  out  4  `ir_instr[11:8]` (jmp/br absolute target).

## Operation
- Two states: EMPTY (`ir_valid`=0) and FULL (`ir_valid`=1). `load_en` = EMPTY, or FULL with `ir_ready`=1.
- Priority each edge, highest first:
  - `rst_n`=0: PC←RESET_PC, `ir_valid`←0, `ir_instr`←0, `ir_pc`←0. The field outputs derive from `ir_instr`, so all decoded outputs reset to 0.
  - `redirect_valid`=1: PC←`redirect_pc`, `ir_valid`←0. This flushes the register whatever `ir_ready` is. A simultaneous `ir_ready` is a don't-care; execute must not treat the flushed word as accepted.
  - `load_en` with jmp fold (see Configuration) and `rom_instr[15:12]`=4'b1000: PC←`rom_instr[11:8]`, `ir_valid`←0.
  - `load_en` otherwise: `ir_instr`←`rom_instr`, `ir_pc`←PC, PC←PC+1 mod 2^PC_W, `ir_valid`←1.
  - Otherwise, FULL and stalled: everything holds, and `ir_instr`/`ir_pc` stay stable while `ir_valid`=1.
- PC wraps 15→0 with no flag.
- The block does no opcode checking except for jmp; unknown opcodes pass through.

## Timing
- ROM is combinational; the fetch→IR latency is 1 cycle.
- First edge after reset release: IR←word[RESET_PC], `ir_valid`=1.
- With `ir_ready` held at 1, throughput is one instruction per cycle. `ir_pc` sequence: 0, 1, 2, …
- Redirect penalty: the edge after the redirect shows `ir_valid`=0. The following edge shows IR←word[`redirect_pc`].
- A folded jmp costs one bubble cycle (`ir_valid`=0) and is never presented downstream.
- A folded jmp to its own address re-folds every cycle, so `ir_valid` stays 0 until a redirect or reset.

## Configuration
- `INSTR_FETCH_JMP_FOLD_EN` defined:
  - opcode 4'b1000 is resolved in fetch as described above.
  - execute never sees jmp.
- Not defined:
  - jmp is loaded into IR like any other instruction, and PC advances sequentially.
  - execute must issue `redirect_valid` with `ir_target` to take it.
  - the jmp fold branch and its comparator are absent.

## Test plan
- Reset/stream: hold `rst_n`=0 for 2 cycles; all outputs 0 during reset. Release with ROM[0..2] = 16'hB401, 16'h3481, 16'hF400 and `ir_ready`=1 → `ir_pc` 0, 1, 2 on successive cycles, `ir_rd`=2 and `ir_imm`=1 for word 0.
- Backpressure: `ir_ready`=0 for 3 cycles while FULL at pc 1 → `ir_instr`=16'h3481 held and PC stays 2. Raising `ir_ready` → next edge `ir_pc`=2.
- Redirect priority: `redirect_valid`=1, `redirect_pc`=10, `ir_ready`=1 in the same cycle → next edge `ir_valid`=0, `rom_addr`=10. Following edge `ir_pc`=10.
- Jmp fold (macro on): ROM[3]=16'h8100 → after pc 2 issues, one cycle with `ir_valid`=0, then `ir_pc`=1. Address 3 never appears on `ir_pc`. Macro off: `ir_pc`=3 with `ir_target`=1, then `ir_pc`=4 unless a redirect arrives.
- Wrap: straight-line ROM, `ir_ready`=1 → `ir_pc` goes 14, 15, 0.
- Mid-stall reset: `rst_n`=0 while FULL and `ir_ready`=0 → next edge `ir_valid`=0, PC=0. After release, word[0] is reissued.
